// File: rtl/axi4lite_timeout_guard_pkg.sv
`default_nettype none
// ============================================================================
// axi4lite_timeout_guard_pkg : FSM state encoding and AXI response codes
// Revision: 1.0
// ============================================================================
package axi4lite_timeout_guard_pkg;

  localparam int unsigned TIMER_W = 16;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_RESP  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_RESP  = 3'd4,
    ST_IN_RESP  = 3'd5,
    ST_DRAIN    = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/axi4lite_timeout_counter.sv
`default_nettype none
// ============================================================================
// axi4lite_timeout_counter : clear/load/enable up-counter, holds at TERMINAL
// Revision: 1.0
// ============================================================================
module axi4lite_timeout_counter
  import axi4lite_timeout_guard_pkg::*;
#(
  parameter logic [TIMER_W-1:0] TERMINAL = '1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [TIMER_W-1:0] load_val_i,
  input  logic               en_i,
  output logic               tc_o
);

  logic [TIMER_W-1:0] count_q, count_d;

  // Holding at terminal keeps the flag asserted if the terminal cycle is
  // consumed by a partial handshake, so a later phase still times out.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && !tc_o) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q >= TERMINAL);

endmodule
`default_nettype wire

// File: rtl/axi4lite_timeout_guard.sv
`default_nettype none
// ============================================================================
// axi4lite_timeout_guard : serialising AXI4-Lite stage that answers SLVERR on a
// hung slave. Optional stats ports: AXI4LITE_TIMEOUT_GUARD_STATS_EN.
// Revision: 1.0
// ============================================================================
module axi4lite_timeout_guard
  import axi4lite_timeout_guard_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF
) (
  input  logic        clk_i,
  input  logic        rst_i,
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
  output logic [15:0] timeout_count_o,
  output logic [31:0] last_fault_addr_o,
  output logic [0:0]  last_fault_wr_o,
`endif
  input  logic        inport_awvalid_i,
  output logic        inport_awready_o,
  input  logic [31:0] inport_awaddr_i,
  input  logic        inport_wvalid_i,
  output logic        inport_wready_o,
  input  logic [31:0] inport_wdata_i,
  input  logic [3:0]  inport_wstrb_i,
  output logic        inport_bvalid_o,
  input  logic        inport_bready_i,
  output logic [1:0]  inport_bresp_o,
  input  logic        inport_arvalid_i,
  output logic        inport_arready_o,
  input  logic [31:0] inport_araddr_i,
  output logic        inport_rvalid_o,
  input  logic        inport_rready_i,
  output logic [31:0] inport_rdata_o,
  output logic [1:0]  inport_rresp_o,
  output logic        outport_awvalid_o,
  input  logic        outport_awready_i,
  output logic [31:0] outport_awaddr_o,
  output logic        outport_wvalid_o,
  input  logic        outport_wready_i,
  output logic [31:0] outport_wdata_o,
  output logic [3:0]  outport_wstrb_o,
  input  logic        outport_bvalid_i,
  output logic        outport_bready_o,
  input  logic [1:0]  outport_bresp_i,
  output logic        outport_arvalid_o,
  input  logic        outport_arready_i,
  output logic [31:0] outport_araddr_o,
  input  logic        outport_rvalid_i,
  output logic        outport_rready_o,
  input  logic [31:0] outport_rdata_i,
  input  logic [1:0]  outport_rresp_i
);

  localparam logic [TIMER_W-1:0] TERMINAL = TIMER_W'(TIMEOUT_CYCLES - 1);

  state_e      state_q, state_d;
  logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
  logic        bvalid_q, bvalid_d, rvalid_q, rvalid_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [1:0]  resp_q, resp_d;
  logic        txn_wr_q, txn_wr_d, rr_last_wr_q, rr_last_wr_d;
  logic        drain_pend_q, drain_pend_d;
  logic        timer_clr, timer_en, timer_tc, timeout;
  logic        grant_wr, grant_rd, idle_ok, wr_done, b_hs, r_hs;

  axi4lite_timeout_counter #(.TERMINAL(TERMINAL)) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (timer_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .en_i       (timer_en),
    .tc_o       (timer_tc)
  );

  // Round-robin: a write wins a tie only when the previous grant was a read.
  assign grant_wr = inport_awvalid_i && inport_wvalid_i && (!inport_arvalid_i || !rr_last_wr_q);
  assign grant_rd = inport_arvalid_i && !grant_wr;
  assign idle_ok  = (state_q == ST_IDLE) && !rst_i;

  assign inport_awready_o = idle_ok && grant_wr;
  assign inport_wready_o  = idle_ok && grant_wr;
  assign inport_arready_o = idle_ok && grant_rd;

  assign outport_bready_o = (state_q == ST_WR_RESP) || (state_q == ST_DRAIN);
  assign outport_rready_o = (state_q == ST_RD_RESP) || (state_q == ST_DRAIN);

  assign wr_done = (!awvalid_q || outport_awready_i) && (!wvalid_q || outport_wready_i);
  assign b_hs    = outport_bvalid_i && outport_bready_o;
  assign r_hs    = outport_rvalid_i && outport_rready_o;

  always_comb begin
    state_d      = state_q;
    awvalid_d    = awvalid_q;
    wvalid_d     = wvalid_q;
    arvalid_d    = arvalid_q;
    bvalid_d     = bvalid_q;
    rvalid_d     = rvalid_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    rdata_d      = rdata_q;
    resp_d       = resp_q;
    txn_wr_d     = txn_wr_q;
    rr_last_wr_d = rr_last_wr_q;
    drain_pend_d = drain_pend_q;
    timer_clr    = 1'b0;
    timer_en     = 1'b0;
    timeout      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        timer_clr = 1'b1;
        if (grant_wr) begin
          addr_d       = inport_awaddr_i;
          wdata_d      = inport_wdata_i;
          wstrb_d      = inport_wstrb_i;
          txn_wr_d     = 1'b1;
          rr_last_wr_d = 1'b1;
          awvalid_d    = 1'b1;
          wvalid_d     = 1'b1;
          state_d      = ST_WR_ISSUE;
        end else if (grant_rd) begin
          addr_d       = inport_araddr_i;
          txn_wr_d     = 1'b0;
          rr_last_wr_d = 1'b0;
          arvalid_d    = 1'b1;
          state_d      = ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        timer_en = 1'b1;
        if (outport_awready_i) awvalid_d = 1'b0;
        if (outport_wready_i)  wvalid_d  = 1'b0;
        if (wr_done)       state_d = ST_WR_RESP;
        else if (timer_tc) timeout = 1'b1;
      end
      ST_WR_RESP: begin
        timer_en = 1'b1;
        if (b_hs) begin
          resp_d   = outport_bresp_i;
          bvalid_d = 1'b1;
          state_d  = ST_IN_RESP;
        end else if (timer_tc) begin
          timeout = 1'b1;
        end
      end
      ST_RD_ISSUE: begin
        timer_en = 1'b1;
        if (outport_arready_i) begin
          arvalid_d = 1'b0;
          state_d   = ST_RD_RESP;
        end else if (timer_tc) begin
          timeout = 1'b1;
        end
      end
      ST_RD_RESP: begin
        timer_en = 1'b1;
        if (r_hs) begin
          resp_d   = outport_rresp_i;
          rdata_d  = outport_rdata_i;
          rvalid_d = 1'b1;
          state_d  = ST_IN_RESP;
        end else if (timer_tc) begin
          timeout = 1'b1;
        end
      end
      ST_IN_RESP: begin
        timer_clr = 1'b1;
        if ((bvalid_q && inport_bready_i) || (rvalid_q && inport_rready_i)) begin
          bvalid_d     = 1'b0;
          rvalid_d     = 1'b0;
          drain_pend_d = 1'b0;
          state_d      = drain_pend_q ? ST_DRAIN : ST_IDLE;
        end
      end
      ST_DRAIN: begin
        timer_en = 1'b1;
        if (b_hs || r_hs || timer_tc) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Hung slave: abandon the outport transaction and answer SLVERR locally.
    if (timeout) begin
      awvalid_d    = 1'b0;
      wvalid_d     = 1'b0;
      arvalid_d    = 1'b0;
      resp_d       = AXI_RESP_SLVERR;
      if (!txn_wr_q) rdata_d = ERR_RDATA;
      bvalid_d     = txn_wr_q;
      rvalid_d     = !txn_wr_q;
      drain_pend_d = 1'b1;
      timer_clr    = 1'b1;
      state_d      = ST_IN_RESP;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      awvalid_q    <= 1'b0;
      wvalid_q     <= 1'b0;
      arvalid_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      rvalid_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
      rdata_q      <= '0;
      resp_q       <= AXI_RESP_OKAY;
      txn_wr_q     <= 1'b0;
      rr_last_wr_q <= 1'b0;
      drain_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      awvalid_q    <= awvalid_d;
      wvalid_q     <= wvalid_d;
      arvalid_q    <= arvalid_d;
      bvalid_q     <= bvalid_d;
      rvalid_q     <= rvalid_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
      rdata_q      <= rdata_d;
      resp_q       <= resp_d;
      txn_wr_q     <= txn_wr_d;
      rr_last_wr_q <= rr_last_wr_d;
      drain_pend_q <= drain_pend_d;
    end
  end

`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
  logic [15:0] timeout_count_q;
  logic [31:0] last_fault_addr_q;
  logic        last_fault_wr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      timeout_count_q   <= '0;
      last_fault_addr_q <= '0;
      last_fault_wr_q   <= 1'b0;
    end else if (timeout) begin
      if (timeout_count_q != 16'hFFFF) timeout_count_q <= timeout_count_q + 16'd1;
      last_fault_addr_q <= addr_q;
      last_fault_wr_q   <= txn_wr_q;
    end
  end

  assign timeout_count_o   = timeout_count_q;
  assign last_fault_addr_o = last_fault_addr_q;
  assign last_fault_wr_o   = last_fault_wr_q;
`endif

  assign outport_awvalid_o = awvalid_q;
  assign outport_wvalid_o  = wvalid_q;
  assign outport_arvalid_o = arvalid_q;
  assign outport_awaddr_o  = addr_q;
  assign outport_araddr_o  = addr_q;
  assign outport_wdata_o   = wdata_q;
  assign outport_wstrb_o   = wstrb_q;
  assign inport_bvalid_o   = bvalid_q;
  assign inport_rvalid_o   = rvalid_q;
  assign inport_bresp_o    = resp_q;
  assign inport_rresp_o    = resp_q;
  assign inport_rdata_o    = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_axi4lite_timeout_guard.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// tb_axi4lite_timeout_guard : scoreboard bench with a reactive slave model
// Revision: 1.0
// ============================================================================
module tb_axi4lite_timeout_guard;

  localparam int unsigned TO = 16;

  logic clk = 1'b0;
  logic rst_i;
  always #5 clk = ~clk;

  logic        inport_awvalid_i, inport_awready_o, inport_wvalid_i, inport_wready_o;
  logic [31:0] inport_awaddr_i, inport_wdata_i, inport_araddr_i, inport_rdata_o;
  logic [3:0]  inport_wstrb_i;
  logic        inport_bvalid_o, inport_bready_i, inport_arvalid_i, inport_arready_o;
  logic        inport_rvalid_o, inport_rready_i;
  logic [1:0]  inport_bresp_o, inport_rresp_o;
  logic        outport_awvalid_o, outport_awready_i, outport_wvalid_o, outport_wready_i;
  logic [31:0] outport_awaddr_o, outport_wdata_o, outport_araddr_o, outport_rdata_i;
  logic [3:0]  outport_wstrb_o;
  logic        outport_bvalid_i, outport_bready_o, outport_arvalid_o, outport_arready_i;
  logic        outport_rvalid_i, outport_rready_o;
  logic [1:0]  outport_bresp_i, outport_rresp_i;
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
  logic [15:0] timeout_count_o;
  logic [31:0] last_fault_addr_o;
  logic [0:0]  last_fault_wr_o;
`endif

  axi4lite_timeout_guard #(.TIMEOUT_CYCLES(TO), .ERR_RDATA(32'hDEADBEEF)) dut (
    .clk_i(clk), .rst_i(rst_i),
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
    .timeout_count_o(timeout_count_o), .last_fault_addr_o(last_fault_addr_o),
    .last_fault_wr_o(last_fault_wr_o),
`endif
    .inport_awvalid_i(inport_awvalid_i), .inport_awready_o(inport_awready_o),
    .inport_awaddr_i(inport_awaddr_i), .inport_wvalid_i(inport_wvalid_i),
    .inport_wready_o(inport_wready_o), .inport_wdata_i(inport_wdata_i),
    .inport_wstrb_i(inport_wstrb_i), .inport_bvalid_o(inport_bvalid_o),
    .inport_bready_i(inport_bready_i), .inport_bresp_o(inport_bresp_o),
    .inport_arvalid_i(inport_arvalid_i), .inport_arready_o(inport_arready_o),
    .inport_araddr_i(inport_araddr_i), .inport_rvalid_o(inport_rvalid_o),
    .inport_rready_i(inport_rready_i), .inport_rdata_o(inport_rdata_o),
    .inport_rresp_o(inport_rresp_o),
    .outport_awvalid_o(outport_awvalid_o), .outport_awready_i(outport_awready_i),
    .outport_awaddr_o(outport_awaddr_o), .outport_wvalid_o(outport_wvalid_o),
    .outport_wready_i(outport_wready_i), .outport_wdata_o(outport_wdata_o),
    .outport_wstrb_o(outport_wstrb_o), .outport_bvalid_i(outport_bvalid_i),
    .outport_bready_o(outport_bready_o), .outport_bresp_i(outport_bresp_i),
    .outport_arvalid_o(outport_arvalid_o), .outport_arready_i(outport_arready_i),
    .outport_araddr_o(outport_araddr_o), .outport_rvalid_i(outport_rvalid_i),
    .outport_rready_o(outport_rready_o), .outport_rdata_i(outport_rdata_i),
    .outport_rresp_i(outport_rresp_i)
  );

  typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] strb; } aw_t;
  typedef struct { logic [31:0] data; logic [1:0] resp; bit lat; } rsp_t;

  aw_t         exp_aw[$];
  logic [31:0] exp_ar[$];
  rsp_t        exp_b[$];
  rsp_t        exp_r[$];
  bit          exp_g[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0, hs_b = -100, hs_r = -100, acc_cyc = -100;

  int          slv_b_lat = 2, slv_r_lat = 5;
  bit          slv_ar_dead = 1'b0;
  logic [1:0]  slv_bresp = 2'b00, slv_rresp = 2'b00;
  logic [31:0] slv_rdata = 32'h0;
  int          bw = -1, rw = -1;
  bit          s_ws, s_ars, s_bd, s_rd, s_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got an unexpected handshake, expected none", name);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor / scoreboard: pops an expectation whenever a handshake is visible.
  initial begin
    rsp_t  r;
    aw_t   a;
    logic [31:0] ad;
    bit    g;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_i) begin
        if (outport_bvalid_i && outport_bready_o) hs_b = cyc;
        if (outport_rvalid_i && outport_rready_o) hs_r = cyc;
        if (inport_awvalid_i && inport_awready_o) begin
          if (exp_g.size() == 0) unexpected("grant");
          else begin g = exp_g.pop_front(); chk("grant_is_write", 32'(g), 32'd1); end
          acc_cyc = cyc;
        end
        if (inport_arvalid_i && inport_arready_o) begin
          if (exp_g.size() == 0) unexpected("grant");
          else begin g = exp_g.pop_front(); chk("grant_is_write", 32'(g), 32'd0); end
          acc_cyc = cyc;
        end
        if (outport_awvalid_o && outport_awready_i) begin
          if (exp_aw.size() == 0) unexpected("out_aw");
          else begin
            a = exp_aw.pop_front();
            chk("out_awaddr", outport_awaddr_o, a.addr);
            chk("out_wdata", outport_wdata_o, a.data);
            chk("out_wstrb", 32'(outport_wstrb_o), 32'(a.strb));
            chk("out_aw_latency", 32'(cyc - acc_cyc), 32'd1);
          end
        end
        if (outport_arvalid_o && outport_arready_i) begin
          if (exp_ar.size() == 0) unexpected("out_ar");
          else begin
            ad = exp_ar.pop_front();
            chk("out_araddr", outport_araddr_o, ad);
            chk("out_ar_latency", 32'(cyc - acc_cyc), 32'd1);
          end
        end
        if (inport_bvalid_o && inport_bready_i) begin
          if (exp_b.size() == 0) unexpected("in_b");
          else begin
            r = exp_b.pop_front();
            chk("in_bresp", 32'(inport_bresp_o), 32'(r.resp));
            if (r.lat) chk("in_b_latency", 32'(cyc - hs_b), 32'd1);
          end
        end
        if (inport_rvalid_o && inport_rready_i) begin
          if (exp_r.size() == 0) unexpected("in_r");
          else begin
            r = exp_r.pop_front();
            chk("in_rdata", inport_rdata_o, r.data);
            chk("in_rresp", 32'(inport_rresp_o), 32'(r.resp));
            if (r.lat) chk("in_r_latency", 32'(cyc - hs_r), 32'd1);
          end
        end
      end
    end
  end

  // Slave model: always-ready AW/W, configurable AR, delayed B/R responses.
  initial begin
    outport_awready_i = 1'b1; outport_wready_i = 1'b1; outport_arready_i = 1'b1;
    outport_bvalid_i = 1'b0; outport_bresp_i = 2'b00;
    outport_rvalid_i = 1'b0; outport_rresp_i = 2'b00; outport_rdata_i = 32'h0;
    forever begin
      @(negedge clk);
      s_rst = rst_i;
      s_ws  = outport_wvalid_o && outport_wready_i;
      s_ars = outport_arvalid_o && outport_arready_i;
      s_bd  = outport_bvalid_i && outport_bready_o;
      s_rd  = outport_rvalid_i && outport_rready_o;
      @(posedge clk);
      #1;
      if (s_rst) begin
        bw = -1; rw = -1;
        outport_bvalid_i = 1'b0; outport_rvalid_i = 1'b0;
      end else begin
        if (s_bd) outport_bvalid_i = 1'b0;
        if (s_rd) outport_rvalid_i = 1'b0;
        if (s_ws) bw = slv_b_lat;
        if (s_ars) rw = slv_r_lat;
        if (bw == 0) begin
          outport_bvalid_i = 1'b1; outport_bresp_i = slv_bresp; bw = -1;
        end else if (bw > 0) bw--;
        if (rw == 0) begin
          outport_rvalid_i = 1'b1; outport_rresp_i = slv_rresp;
          outport_rdata_i = slv_rdata; rw = -1;
        end else if (rw > 0) rw--;
      end
      outport_arready_i = !slv_ar_dead;
    end
  end

  task automatic issue_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    bit hs = 1'b0;
    inport_awaddr_i = a; inport_wdata_i = d; inport_wstrb_i = s;
    inport_awvalid_i = 1'b1; inport_wvalid_i = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = inport_awready_o && inport_wready_o;
      tick();
    end
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0;
    if (!hs) unexpected("write_accept_timeout");
  endtask

  task automatic issue_read(input logic [31:0] a);
    bit hs = 1'b0;
    inport_araddr_i = a;
    inport_arvalid_i = 1'b1;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clk);
      hs = inport_arready_o;
      tick();
    end
    inport_arvalid_i = 1'b0;
    if (!hs) unexpected("read_accept_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while ((exp_g.size() + exp_aw.size() + exp_ar.size() + exp_b.size() + exp_r.size()) != 0
           && n < 300) begin
      tick();
      n++;
    end
    chk("pending_expectations", 32'(exp_g.size() + exp_aw.size() + exp_ar.size()
        + exp_b.size() + exp_r.size()), 32'd0);
    exp_g.delete(); exp_aw.delete(); exp_ar.delete(); exp_b.delete(); exp_r.delete();
    tick();
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [1:0] resp, input bit lat);
    aw_t  x;
    rsp_t r;
    x.addr = a; x.data = d; x.strb = s;
    r.data = 32'h0; r.resp = resp; r.lat = lat;
    exp_aw.push_back(x);
    exp_b.push_back(r);
  endtask

  task automatic push_rd(input logic [31:0] a, input logic [31:0] d, input logic [1:0] resp,
                         input bit lat, input bit ar_hs);
    rsp_t r;
    r.data = d; r.resp = resp; r.lat = lat;
    if (ar_hs) exp_ar.push_back(a);
    exp_r.push_back(r);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    inport_awvalid_i = 1'b0; inport_wvalid_i = 1'b0; inport_arvalid_i = 1'b0;
    inport_awaddr_i = 32'h0; inport_wdata_i = 32'h0; inport_wstrb_i = 4'h0;
    inport_araddr_i = 32'h0; inport_bready_i = 1'b1; inport_rready_i = 1'b1;
    repeat (3) tick();
    rst_i = 1'b0;

    @(negedge clk);
    chk("rst_valids_readies", 32'({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
        outport_bready_o, outport_rready_o, inport_bvalid_o, inport_rvalid_o}), 32'd0);
    chk("rst_resps", 32'({inport_bresp_o, inport_rresp_o}), 32'd0);
    chk("rst_rdata", inport_rdata_o, 32'd0);
    chk("rst_addr", outport_awaddr_o, 32'd0);
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
    chk("rst_timeout_count", 32'(timeout_count_o), 32'd0);
`endif
    tick();

    // Single write, OKAY after 2 cycles
    slv_b_lat = 2; slv_bresp = 2'b00;
    exp_g.push_back(1'b1);
    push_wr(32'h9000_0004, 32'h1234_5678, 4'hF, 2'b00, 1'b1);
    issue_write(32'h9000_0004, 32'h1234_5678, 4'hF);
    wait_done();

    // Read, data after 5 cycles
    slv_r_lat = 5; slv_rdata = 32'hCAFE_F00D; slv_rresp = 2'b00;
    exp_g.push_back(1'b0);
    push_rd(32'h9000_0000, 32'hCAFE_F00D, 2'b00, 1'b1, 1'b1);
    issue_read(32'h9000_0000);
    wait_done();

    // Slave DECERR passes through untouched
    slv_r_lat = 1; slv_rdata = 32'h0BAD_F00D; slv_rresp = 2'b11;
    exp_g.push_back(1'b0);
    push_rd(32'h9000_0008, 32'h0BAD_F00D, 2'b11, 1'b1, 1'b1);
    issue_read(32'h9000_0008);
    wait_done();
    slv_rresp = 2'b00;

    // Read to a slave that never accepts AR
    slv_ar_dead = 1'b1;
    exp_g.push_back(1'b0);
    push_rd(32'h9000_0010, 32'hDEAD_BEEF, 2'b10, 1'b0, 1'b0);
    issue_read(32'h9000_0010);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (outport_arvalid_o) n++;
    end
    chk("arvalid_cycles_before_timeout", 32'(n), 32'(TO));
    wait_done();
    slv_ar_dead = 1'b0;
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
    chk("stats_count_1", 32'(timeout_count_o), 32'd1);
    chk("stats_addr_1", last_fault_addr_o, 32'h9000_0010);
    chk("stats_wr_1", 32'(last_fault_wr_o), 32'd0);
`endif

    // Write whose bvalid arrives after the timeout; must be absorbed
    slv_b_lat = 20;
    exp_g.push_back(1'b1);
    push_wr(32'h9000_0020, 32'hA5A5_A5A5, 4'h3, 2'b10, 1'b0);
    issue_write(32'h9000_0020, 32'hA5A5_A5A5, 4'h3);
    wait_done();
    slv_b_lat = 2; slv_r_lat = 1; slv_rdata = 32'h1122_3344;
    exp_g.push_back(1'b0);
    push_rd(32'h9000_0024, 32'h1122_3344, 2'b00, 1'b1, 1'b1);
    issue_read(32'h9000_0024);
    wait_done();
`ifdef AXI4LITE_TIMEOUT_GUARD_STATS_EN
    chk("stats_count_2", 32'(timeout_count_o), 32'd2);
    chk("stats_addr_2", last_fault_addr_o, 32'h9000_0020);
    chk("stats_wr_2", 32'(last_fault_wr_o), 32'd1);
`endif

    // Round-robin from a fresh reset: W,R then lone W then R,W
    rst_i = 1'b1;
    repeat (2) tick();
    rst_i = 1'b0;
    tick();
    slv_rdata = 32'h5555_0001;
    exp_g.push_back(1'b1); exp_g.push_back(1'b0);
    push_wr(32'h9000_0100, 32'h0000_0001, 4'h1, 2'b00, 1'b1);
    push_rd(32'h9000_0104, 32'h5555_0001, 2'b00, 1'b1, 1'b1);
    fork
      issue_write(32'h9000_0100, 32'h0000_0001, 4'h1);
      issue_read(32'h9000_0104);
    join
    wait_done();
    exp_g.push_back(1'b1);
    push_wr(32'h9000_0108, 32'h0000_0002, 4'h2, 2'b00, 1'b1);
    issue_write(32'h9000_0108, 32'h0000_0002, 4'h2);
    wait_done();
    slv_rdata = 32'h5555_0002;
    exp_g.push_back(1'b0); exp_g.push_back(1'b1);
    push_rd(32'h9000_010C, 32'h5555_0002, 2'b00, 1'b1, 1'b1);
    push_wr(32'h9000_0110, 32'h0000_0003, 4'hC, 2'b00, 1'b1);
    fork
      issue_write(32'h9000_0110, 32'h0000_0003, 4'hC);
      issue_read(32'h9000_010C);
    join
    wait_done();

    // Reset while waiting for B: no response may ever reach the inport
    slv_b_lat = 10;
    exp_g.push_back(1'b1);
    begin
      aw_t x;
      x.addr = 32'h9000_0200; x.data = 32'hFEED_0000; x.strb = 4'hF;
      exp_aw.push_back(x);
    end
    issue_write(32'h9000_0200, 32'hFEED_0000, 4'hF);
    n = 0;
    while (n < 20 && !outport_bready_o) begin
      @(negedge clk);
      n++;
    end
    chk("reached_wr_resp", 32'(outport_bready_o), 32'd1);
    tick();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    @(negedge clk);
    chk("post_rst_valids_readies", 32'({outport_awvalid_o, outport_wvalid_o, outport_arvalid_o,
        outport_bready_o, outport_rready_o, inport_bvalid_o, inport_rvalid_o}), 32'd0);
    repeat (25) tick();
    wait_done();
    slv_b_lat = 2; slv_rdata = 32'h7777_8888;
    exp_g.push_back(1'b0);
    push_rd(32'h9000_0204, 32'h7777_8888, 2'b00, 1'b1, 1'b1);
    issue_read(32'h9000_0204);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
